alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational Mini-ALU datapath (6-bit A/B operands, opcode select, 6-bit result X) between two requesters.
- Arbitrates round-robin and latches the winner's operands and opcode.
- Drives the ALU for a fixed number of settle cycles, captures X, and returns it to the winner over a valid/ready response channel.
- Sits between the Mini-ALU operation units/mux and the front-end logic that issues operations.

Parameters:
- WIDTH, 6, operand and result width; must match the ALU datapath.
- OPW, 3, opcode width driven to the ALU result mux.
- EXEC_CYCLES, 1, cycles alu_a/alu_b/alu_op are held before X is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_op  input  OPW  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  as requester 0, for requester 1.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_op  output  OPW  registered opcode to the ALU.
- alu_x  input  WIDTH  ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  WIDTH  captured result.
- rsp_id  output  1  requester the result belongs to (0/1).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; alu_a=0, alu_b=0, alu_op=0; rsp_valid=0, rsp_data=0, rsp_id=0; busy=0; priority pointer=0 (requester 0 favoured).
- req0_ready and req1_ready are forced 0 while rst_n=0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, arbitration (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester named by the priority pointer wins.
  - reqN_ready=1 only for the winner, only in IDLE; every other ready is 0.
- IDLE, accept (reqN_valid & reqN_ready on a clock edge):
  - Latch op/a/b into alu_op/alu_a/alu_b.
  - Latch winner index into rsp_id.
  - Set pointer to the other requester.
  - Load settle counter with EXEC_CYCLES-1.
  - Go to EXEC.
- IDLE, no valid: stay; pointer unchanged.
- EXEC:
  - alu_a/alu_b/alu_op are held stable.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: sample alu_x into rsp_data, set rsp_valid=1, go to RESP.
  - EXEC lasts exactly EXEC_CYCLES cycles.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - ALU outputs keep their last values; they are not cleared.
- Latency: accept edge to rsp_valid high is EXEC_CYCLES+1 edges.
- Throughput with rsp_ready tied high: one operation every EXEC_CYCLES+2 cycles.
- Requests presented while busy are not accepted; those requesters see ready=0.
- Requesters hold valid and payload until ready. A requester that drops valid in IDLE before acceptance simply loses arbitration; no state change.
- Fairness: with both requesters continuously valid, grants alternate strictly 0,1,0,1...
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is discarded and no response is issued.
  - All outputs and the pointer return to reset values on that edge.
- rsp_ready high outside RESP is ignored.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
1. Bench ALU model with op 3'b101 = XNOR, EXEC_CYCLES=1. Single req0: a=6'b101010, b=6'b110011, op=3'b101 -> req0_ready pulses 1 cycle; rsp_valid 2 edges later; rsp_data=6'b100110; rsp_id=0.
2. Both requesters valid from reset, rsp_ready=1: req0 a=6'h3F/b=6'h00, req1 a=6'h15/b=6'h15, op XNOR -> grant order 0,1,0,1; rsp_data 6'h00 for id0 and 6'h3F for id1; one response every 3 cycles.
3. rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; both req readys stay 0; IDLE entered the cycle after rsp_ready rises.
4. EXEC_CYCLES=4, bench ALU returns X only after a 3-cycle delay -> alu_a/alu_b stable for 4 cycles; correct X captured; latency 5 edges.
5. Assert rst_n=0 for 1 cycle during EXEC -> no rsp_valid; busy=0; next simultaneous request is granted to requester 0.
6. req1 alone, then req0 and req1 together -> req1 granted first, then req0 (pointer moved to 0), then req1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational Mini-ALU between two requesters.
// Latches the winner's operands, holds them for EXEC_CYCLES, then returns the sampled result.
module alu_share_arbiter #(
  parameter int WIDTH       = 6,
  parameter int OPW         = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_x,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state, state_d;
  logic       ptr;
  logic [3:0] cnt;
  logic       grant0, grant1;

  // Ready is the registered-state-qualified grant, so an accept is simply valid & ready.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !ptr);
    grant1     = req1_valid && (!req0_valid ||  ptr);
    req0_ready = rst_n && (state == IDLE) && grant0;
    req1_ready = rst_n && (state == IDLE) && grant1;
    state_d    = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    if (cnt == '0)        state_d = RESP;
      RESP:    if (rsp_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a  <= req0_a;
            alu_b  <= req0_b;
            alu_op <= req0_op;
            rsp_id <= 1'b0;
            ptr    <= 1'b1;
            cnt    <= CNT_INIT;
          end else if (req1_ready) begin
            alu_a  <= req1_a;
            alu_b  <= req1_b;
            alu_op <= req1_op;
            rsp_id <= 1'b1;
            ptr    <= 1'b0;
            cnt    <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= alu_x;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
